issue_scoreboard: RTL and testbench



---
 rtl/issue_scoreboard_if.sv | 32 +++
 rtl/issue_scoreboard.sv | 114 +++++++++++
 tb/tb_issue_scoreboard.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/issue_scoreboard_if.sv
// Decode/execute side bundle of the issue scoreboard: decode request fields in,
// stall, registered execute select and pending-write vector out.
interface issue_scoreboard_if;
    logic        id_is_valid;
    logic [1:0]  id_is_functionalunit;
    logic [4:0]  id_is_rs;
    logic        id_is_usesrs;
    logic [4:0]  id_is_rt;
    logic        id_is_usesrt;
    logic [4:0]  id_is_regdest;
    logic        id_is_writereg;

    logic        is_id_stall;
    logic [1:0]  is_fu_functionalunit;
    logic [4:0]  is_fu_regdest;
    logic        is_fu_writereg;
    logic [31:0] is_pending;

    modport master (
        output id_is_valid, id_is_functionalunit, id_is_rs, id_is_usesrs,
               id_is_rt, id_is_usesrt, id_is_regdest, id_is_writereg,
        input  is_id_stall, is_fu_functionalunit, is_fu_regdest,
               is_fu_writereg, is_pending
    );

    modport slave (
        input  id_is_valid, id_is_functionalunit, id_is_rs, id_is_usesrs,
               id_is_rt, id_is_usesrt, id_is_regdest, id_is_writereg,
        output is_id_stall, is_fu_functionalunit, is_fu_regdest,
               is_fu_writereg, is_pending
    );
endinterface

// File: rtl/issue_scoreboard.sv
// In-order issue scoreboard: blocks RAW/WAW hazards on pending destinations and
// reserves the single shared writeback port so mixed-latency units never collide.
module issue_scoreboard #(
    parameter int LAT_X = 4,
    parameter int LAT_M = 6,
    parameter int LAT_L = 3
) (
    input  logic              clock,
    input  logic              reset,
    issue_scoreboard_if.slave bus
);
    localparam int LAT_XM  = (LAT_X > LAT_M) ? LAT_X : LAT_M;
    localparam int LAT_MAX = (LAT_XM > LAT_L) ? LAT_XM : LAT_L;
    localparam int D       = LAT_MAX + 2;

    // Slot d describes the writeback d cycles ahead of the current cycle.
    logic [D-1:0]      r_wbBusy;
    logic [D-1:0][4:0] r_wbRd;
    logic [31:0]       r_pending;
    logic [1:0]        r_fu;
    logic [4:0]        r_fuRd;
    logic              r_fuWr;

    int                w_lat;
    logic              w_raw;
    logic              w_waw;
    logic              w_structural;
    logic              w_stall;
    logic              w_issue;
    logic              w_reserve;
    logic [D-1:0]      w_busyNext;
    logic [D-1:0][4:0] w_rdNext;
    logic [31:0]       w_setMask;
    logic [31:0]       w_clearMask;
    logic [31:0]       w_pendingNext;

    always_comb begin
        unique case (bus.id_is_functionalunit)
            2'd1:    w_lat = LAT_X;
            2'd2:    w_lat = LAT_M;
            2'd3:    w_lat = LAT_L;
            default: w_lat = 0;
        endcase
    end

    // The writeback lands L+1 cycles ahead because execute starts on the next cycle.
    always_comb begin
        w_structural = 1'b0;
        for (int d = 1; d < D; d++) begin
            if (d == w_lat + 1) begin
                w_structural = r_wbBusy[d];
            end
        end
        w_structural = w_structural & bus.id_is_writereg &
                       (bus.id_is_functionalunit != 2'd0);
    end

    always_comb begin
        w_raw     = (bus.id_is_usesrs & r_pending[bus.id_is_rs]) |
                    (bus.id_is_usesrt & r_pending[bus.id_is_rt]);
        w_waw     = bus.id_is_writereg & r_pending[bus.id_is_regdest];
        w_stall   = bus.id_is_valid & (w_raw | w_waw | w_structural);
        w_issue   = bus.id_is_valid & ~w_stall;
        w_reserve = w_issue & bus.id_is_writereg & (bus.id_is_functionalunit != 2'd0);
    end

    always_comb begin
        w_busyNext = {1'b0, r_wbBusy[D-1:1]};
        w_rdNext   = {5'd0, r_wbRd[D-1:1]};
        for (int d = 0; d < D; d++) begin
            if (w_reserve && d == w_lat) begin
                w_busyNext[d] = 1'b1;
                w_rdNext[d]   = bus.id_is_regdest;
            end
        end
    end

    // A set on the same edge as a clear wins; register 0 is never tracked.
    always_comb begin
        w_clearMask = '0;
        if (r_wbBusy[0]) begin
            w_clearMask[r_wbRd[0]] = 1'b1;
        end
        w_setMask = '0;
        if (w_reserve && bus.id_is_regdest != 5'd0) begin
            w_setMask[bus.id_is_regdest] = 1'b1;
        end
        w_pendingNext = ((r_pending & ~w_clearMask) | w_setMask) & 32'hFFFF_FFFE;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_wbBusy  <= '0;
            r_wbRd    <= '0;
            r_pending <= '0;
            r_fu      <= 2'd0;
            r_fuRd    <= 5'd0;
            r_fuWr    <= 1'b0;
        end else begin
            r_wbBusy  <= w_busyNext;
            r_wbRd    <= w_rdNext;
            r_pending <= w_pendingNext;
            r_fu      <= w_issue ? bus.id_is_functionalunit : 2'd0;
            r_fuRd    <= w_issue ? bus.id_is_regdest : 5'd0;
            r_fuWr    <= w_issue & bus.id_is_writereg;
        end
    end

    assign bus.is_id_stall          = w_stall;
    assign bus.is_fu_functionalunit = r_fu;
    assign bus.is_fu_regdest        = r_fuRd;
    assign bus.is_fu_writereg       = r_fuWr;
    assign bus.is_pending           = r_pending;
endmodule

// File: tb/tb_issue_scoreboard.sv
// Bench for issue_scoreboard: directed cycle tables, dependent-spacing sequences
// and a randomized run against an absolute-cycle reference model.
module tb_issue_scoreboard;
    localparam int LAT_X = 4;
    localparam int LAT_M = 6;
    localparam int LAT_L = 3;

    logic clock = 1'b0;
    logic reset = 1'b0;

    issue_scoreboard_if bus();

    issue_scoreboard #(
        .LAT_X(LAT_X),
        .LAT_M(LAT_M),
        .LAT_L(LAT_L)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit        doReset;
        bit        rstn;
        bit        valid;
        bit [1:0]  fu;
        bit [4:0]  rs;
        bit        usesRs;
        bit [4:0]  rt;
        bit        usesRt;
        bit [4:0]  rd;
        bit        writeReg;
        bit        expStall;
        bit [1:0]  expFu;
        bit [4:0]  expRd;
        bit        expWr;
        bit [31:0] expPend;
    } vector_t;

    typedef struct {
        bit [4:0] rd;
        longint   wbCyc;
    } wb_t;

    vector_t vectors[$];
    wb_t     outstanding[$];
    int      checkCount = 0;
    int      passCount  = 0;

    function automatic void addVec(input int doReset, input int rstn, input int valid,
                                   input int fu, input int rs, input int usesRs,
                                   input int rt, input int usesRt, input int rd,
                                   input int writeReg, input int expStall, input int expFu,
                                   input int expRd, input int expWr, input int expPend);
        vector_t v;
        v.doReset  = 1'(doReset);
        v.rstn     = 1'(rstn);
        v.valid    = 1'(valid);
        v.fu       = 2'(fu);
        v.rs       = 5'(rs);
        v.usesRs   = 1'(usesRs);
        v.rt       = 5'(rt);
        v.usesRt   = 1'(usesRt);
        v.rd       = 5'(rd);
        v.writeReg = 1'(writeReg);
        v.expStall = 1'(expStall);
        v.expFu    = 2'(expFu);
        v.expRd    = 5'(expRd);
        v.expWr    = 1'(expWr);
        v.expPend  = 32'(expPend);
        vectors.push_back(v);
    endfunction

    task automatic drive(input bit valid, input bit [1:0] fu, input bit [4:0] rs,
                         input bit usesRs, input bit [4:0] rt, input bit usesRt,
                         input bit [4:0] rd, input bit writeReg);
        bus.id_is_valid          = valid;
        bus.id_is_functionalunit = fu;
        bus.id_is_rs             = rs;
        bus.id_is_usesrs         = usesRs;
        bus.id_is_rt             = rt;
        bus.id_is_usesrt         = usesRt;
        bus.id_is_regdest        = rd;
        bus.id_is_writereg       = writeReg;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t",
                     name, actual, expected, $time);
        end
    endtask

    task automatic pulseReset();
        drive(1'b0, 2'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        reset = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    task automatic applyStimulus(input vector_t v, input int idx);
        if (v.doReset) begin
            pulseReset();
        end
        drive(v.valid, v.fu, v.rs, v.usesRs, v.rt, v.usesRt, v.rd, v.writeReg);
        reset = v.rstn;
        #1;
        checkOutput($sformatf("vec%0d.stall", idx), 32'(bus.is_id_stall), 32'(v.expStall));
        checkOutput($sformatf("vec%0d.fu", idx), 32'(bus.is_fu_functionalunit), 32'(v.expFu));
        checkOutput($sformatf("vec%0d.rd", idx), 32'(bus.is_fu_regdest), 32'(v.expRd));
        checkOutput($sformatf("vec%0d.wr", idx), 32'(bus.is_fu_writereg), 32'(v.expWr));
        checkOutput($sformatf("vec%0d.pend", idx), bus.is_pending, v.expPend);
        @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    // Producer in cycle 0, consumer of its result presented from cycle 1 onward.
    task automatic checkSpacing(input bit [1:0] fu, input int lat, input string name);
        int n;
        bit done;
        pulseReset();
        drive(1'b1, fu, 5'd0, 1'b0, 5'd0, 1'b0, 5'd20, 1'b1);
        @(posedge clock);
        #1;
        drive(1'b1, 2'd1, 5'd20, 1'b1, 5'd0, 1'b0, 5'd21, 1'b0);
        done = 1'b0;
        n = 1;
        while (!done && n < 40) begin
            #1;
            if (!bus.is_id_stall) begin
                done = 1'b1;
            end else begin
                @(posedge clock);
                #1;
                n++;
            end
        end
        checkOutput(name, 32'(n), 32'(lat + 2));
        @(posedge clock);
        #1;
        drive(1'b0, 2'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    endtask

    function automatic int latOf(input bit [1:0] fu);
        case (fu)
            2'd1:    return LAT_X;
            2'd2:    return LAT_M;
            2'd3:    return LAT_L;
            default: return 0;
        endcase
    endfunction

    function automatic bit [31:0] modelPending();
        bit [31:0] p = '0;
        foreach (outstanding[i]) begin
            if (outstanding[i].rd != 5'd0) p[outstanding[i].rd] = 1'b1;
        end
        return p;
    endfunction

    function automatic bit wbTaken(input longint w);
        foreach (outstanding[i]) begin
            if (outstanding[i].wbCyc == w) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic runRandom(input int cycles);
        longint    cyc;
        bit        valid, usesRs, usesRt, wr, rstn, held, expStall, issue;
        bit [1:0]  fu, mFu;
        bit [4:0]  rs, rt, rd, mRd;
        bit        mWr;
        bit [31:0] expPend;
        int        lat;
        wb_t       e;
        pulseReset();
        outstanding.delete();
        cyc = 0;
        held = 1'b0;
        mFu = 2'd0;
        mRd = 5'd0;
        mWr = 1'b0;
        valid = 1'b0; fu = 2'd0; rs = 5'd0; rt = 5'd0; rd = 5'd0;
        usesRs = 1'b0; usesRt = 1'b0; wr = 1'b0;
        for (int k = 0; k < cycles; k++) begin
            for (int i = outstanding.size() - 1; i >= 0; i--) begin
                if (outstanding[i].wbCyc < cyc) outstanding.delete(i);
            end
            if (!held) begin
                valid  = ($urandom_range(0, 9) < 7);
                fu     = 2'($urandom_range(0, 3));
                rs     = 5'($urandom_range(0, 7));
                rt     = 5'($urandom_range(0, 7));
                rd     = 5'($urandom_range(0, 7));
                usesRs = 1'($urandom_range(0, 1));
                usesRt = 1'($urandom_range(0, 1));
                wr     = ($urandom_range(0, 3) != 0);
            end
            rstn = ($urandom_range(0, 39) != 0);
            drive(valid, fu, rs, usesRs, rt, usesRt, rd, wr);
            reset = rstn;
            expPend = modelPending();
            lat = latOf(fu);
            expStall = valid && ((usesRs && expPend[rs]) || (usesRt && expPend[rt]) ||
                                 (wr && expPend[rd]) ||
                                 (wr && fu != 2'd0 && wbTaken(cyc + 1 + longint'(lat))));
            #1;
            checkOutput($sformatf("rand%0d.stall", k), 32'(bus.is_id_stall), 32'(expStall));
            checkOutput($sformatf("rand%0d.fu", k), 32'(bus.is_fu_functionalunit), 32'(mFu));
            checkOutput($sformatf("rand%0d.rd", k), 32'(bus.is_fu_regdest), 32'(mRd));
            checkOutput($sformatf("rand%0d.wr", k), 32'(bus.is_fu_writereg), 32'(mWr));
            checkOutput($sformatf("rand%0d.pend", k), bus.is_pending, expPend);
            if (!rstn) begin
                outstanding.delete();
                mFu = 2'd0;
                mRd = 5'd0;
                mWr = 1'b0;
                held = 1'b0;
            end else begin
                issue = valid && !expStall;
                mFu = issue ? fu : 2'd0;
                mRd = issue ? rd : 5'd0;
                mWr = issue && wr;
                if (issue && wr && fu != 2'd0) begin
                    e.rd = rd;
                    e.wbCyc = cyc + 1 + longint'(lat);
                    outstanding.push_back(e);
                end
                held = valid && expStall;
            end
            @(posedge clock);
            #1;
            reset = 1'b1;
            cyc++;
        end
    endtask

    // Each row is one cycle: inputs presented, then stall and registered outputs seen in it.
    task automatic buildVectors();
        addVec(1,1,0,0,0,0,0,0,0,0, 0,0,0,0,32'h0);
        addVec(0,1,0,0,0,0,0,0,0,0, 0,0,0,0,32'h0);
        addVec(0,1,0,0,0,0,0,0,0,0, 0,0,0,0,32'h0);

        addVec(1,1,1,1,0,0,0,0,5,1, 0,0,0,0,32'h0);
        addVec(0,1,1,1,5,1,0,0,6,1, 1,1,5,1,32'h20);
        for (int i = 0; i < 4; i++) addVec(0,1,1,1,5,1,0,0,6,1, 1,0,0,0,32'h20);
        addVec(0,1,1,1,5,1,0,0,6,1, 0,0,0,0,32'h0);
        addVec(0,1,0,0,0,0,0,0,0,0, 0,1,6,1,32'h40);

        addVec(1,1,1,2,0,0,0,0,3,1, 0,0,0,0,32'h0);
        addVec(0,1,0,0,0,0,0,0,0,0, 0,2,3,1,32'h8);
        addVec(0,1,1,1,0,0,0,0,4,1, 1,0,0,0,32'h8);
        addVec(0,1,1,1,0,0,0,0,4,1, 0,0,0,0,32'h8);
        addVec(0,1,0,0,0,0,0,0,0,0, 0,1,4,1,32'h18);
        for (int i = 0; i < 3; i++) addVec(0,1,0,0,0,0,0,0,0,0, 0,0,0,0,32'h18);
        addVec(0,1,0,0,0,0,0,0,0,0, 0,0,0,0,32'h10);
        addVec(0,1,0,0,0,0,0,0,0,0, 0,0,0,0,32'h0);

        addVec(1,1,1,2,0,0,0,0,9,1, 0,0,0,0,32'h0);
        addVec(0,1,1,3,0,0,0,0,9,1, 1,2,9,1,32'h200);
        for (int i = 0; i < 6; i++) addVec(0,1,1,3,0,0,0,0,9,1, 1,0,0,0,32'h200);
        addVec(0,1,1,3,0,0,0,0,9,1, 0,0,0,0,32'h0);
        addVec(0,1,0,0,0,0,0,0,0,0, 0,3,9,1,32'h200);

        addVec(1,1,1,1,0,0,0,0,0,1, 0,0,0,0,32'h0);
        addVec(0,1,1,1,0,1,0,0,0,0, 0,1,0,1,32'h0);
        addVec(0,1,1,1,0,0,0,0,10,1, 0,1,0,0,32'h0);
        addVec(0,1,1,3,0,0,0,0,11,1, 1,1,10,1,32'h400);
        addVec(0,1,1,3,0,0,0,0,11,1, 0,0,0,0,32'h400);
        addVec(0,1,0,0,0,0,0,0,0,0, 0,3,11,1,32'hC00);

        addVec(1,1,1,2,0,0,0,0,7,1, 0,0,0,0,32'h0);
        addVec(0,1,0,0,0,0,0,0,0,0, 0,2,7,1,32'h80);
        addVec(0,0,0,0,0,0,0,0,0,0, 0,0,0,0,32'h80);
        addVec(0,1,1,1,0,0,0,0,7,1, 0,0,0,0,32'h0);
        addVec(0,1,0,0,0,0,0,0,0,0, 0,1,7,1,32'h80);
    endtask

    initial begin
        drive(1'b0, 2'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        buildVectors();
        foreach (vectors[i]) applyStimulus(vectors[i], i);
        checkSpacing(2'd1, LAT_X, "spacing.X");
        checkSpacing(2'd2, LAT_M, "spacing.M");
        checkSpacing(2'd3, LAT_L, "spacing.L");
        runRandom(600);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
